// File: rtl/vga_timing_gen_pkg.sv
// Shared timing constants and coordinate type for the VGA raster generator.
package vga_pkg;
  // 640x480 @ 60 Hz defaults
  localparam int H_ACTIVE_D = 640;
  localparam int H_FP_D     = 16;
  localparam int H_SYNC_D   = 96;
  localparam int H_BP_D     = 48;
  localparam int V_ACTIVE_D = 480;
  localparam int V_FP_D     = 10;
  localparam int V_SYNC_D   = 2;
  localparam int V_BP_D     = 33;

  localparam int H_TOTAL_D  = H_ACTIVE_D + H_FP_D + H_SYNC_D + H_BP_D;
  localparam int V_TOTAL_D  = V_ACTIVE_D + V_FP_D + V_SYNC_D + V_BP_D;
  localparam int HS_START_D = H_ACTIVE_D + H_FP_D;
  localparam int HS_END_D   = HS_START_D + H_SYNC_D;
  localparam int VS_START_D = V_ACTIVE_D + V_FP_D;
  localparam int VS_END_D   = VS_START_D + V_SYNC_D;

  localparam int CW = 10;
  typedef logic [CW-1:0] coord_t;
endpackage

// File: rtl/vga_timing_gen_if.sv
// Raster output bundle: timing generator drives, pixel logic consumes.
interface vga_timing_gen_if;
  import vga_pkg::*;
  logic   hsync_o;
  logic   vsync_o;
  logic   de_o;
  coord_t x_o;
  coord_t y_o;
  logic   line_start_o;
  logic   frame_start_o;

  modport master (output hsync_o, vsync_o, de_o, x_o, y_o, line_start_o, frame_start_o);
  modport slave  (input  hsync_o, vsync_o, de_o, x_o, y_o, line_start_o, frame_start_o);
endinterface

// File: rtl/vga_timing_gen_wrap_cnt.sv
// Modulo-N counter with synchronous clear, increment enable and terminal count.
module vga_wrap_cnt
  import vga_pkg::*;
#(
  parameter int N = 800
) (
  input  logic   clk_i,
  input  logic   rst_i,
  input  logic   clr_i,
  input  logic   inc_i,
  output coord_t cnt_o,
  output logic   tc_o
);
  localparam coord_t LAST = coord_t'(N - 1);

  coord_t cnt_d, cnt_q;

  // next count: clear wins, otherwise wrap at N-1 when enabled
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)      cnt_d = '0;
    else if (inc_i) cnt_d = (cnt_q == LAST) ? '0 : cnt_q + coord_t'(1);
  end

  // count register
  always_ff @(posedge clk_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;
  assign tc_o  = (cnt_q == LAST);
endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing: pixel/line counters plus registered sync, DE, coordinates
// and start strobes. Lock loss behaves like reset so the raster restarts at (0,0).
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int   H_ACTIVE    = H_ACTIVE_D,
  parameter int   H_FP        = H_FP_D,
  parameter int   H_SYNC      = H_SYNC_D,
  parameter int   H_BP        = H_BP_D,
  parameter int   V_ACTIVE    = V_ACTIVE_D,
  parameter int   V_FP        = V_FP_D,
  parameter int   V_SYNC      = V_SYNC_D,
  parameter int   V_BP        = V_BP_D,
  parameter logic SYNC_ACTIVE = 1'b0
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              lock_i,
  vga_timing_gen_if.master  vga
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam coord_t HA_C = coord_t'(H_ACTIVE);
  localparam coord_t VA_C = coord_t'(V_ACTIVE);
  localparam coord_t HS_S = coord_t'(H_ACTIVE + H_FP);
  localparam coord_t HS_E = coord_t'(H_ACTIVE + H_FP + H_SYNC);
  localparam coord_t VS_S = coord_t'(V_ACTIVE + V_FP);
  localparam coord_t VS_E = coord_t'(V_ACTIVE + V_FP + V_SYNC);

  // 10-bit counters cannot represent a larger raster
  if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_size_chk
    $error("vga_timing_gen: H_TOTAL/V_TOTAL must not exceed 1024");
  end

  logic   clr;
  coord_t h, v;
  logic   h_tc, v_tc;

  assign clr = rst_i | ~lock_i;

  vga_wrap_cnt #(.N(H_TOTAL)) u_hcnt (
    .clk_i (clk_i), .rst_i (rst_i), .clr_i (clr), .inc_i (1'b1),
    .cnt_o (h), .tc_o (h_tc)
  );

  vga_wrap_cnt #(.N(V_TOTAL)) u_vcnt (
    .clk_i (clk_i), .rst_i (rst_i), .clr_i (clr), .inc_i (h_tc),
    .cnt_o (v), .tc_o (v_tc)
  );

  logic   hsync_d, vsync_d, de_d, ls_d, fs_d;
  logic   hsync_q, vsync_q, de_q, ls_q, fs_q;
  coord_t x_d, y_d, x_q, y_q;

  // decode the current (h, v) into the values registered this edge
  always_comb begin
    hsync_d = ~SYNC_ACTIVE;
    vsync_d = ~SYNC_ACTIVE;
    de_d    = 1'b0;
    x_d     = '0;
    y_d     = '0;
    ls_d    = 1'b0;
    fs_d    = 1'b0;
    if (!clr) begin
      x_d     = h;
      y_d     = v;
      de_d    = (h < HA_C) && (v < VA_C);
      hsync_d = (h >= HS_S && h < HS_E) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
      vsync_d = (v >= VS_S && v < VS_E) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
      ls_d    = (h == '0);
      fs_d    = (h == '0) && (v == '0);
    end
  end

  // output registers, all aligned on the same edge
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      hsync_q <= ~SYNC_ACTIVE;
      vsync_q <= ~SYNC_ACTIVE;
      de_q    <= 1'b0;
      x_q     <= '0;
      y_q     <= '0;
      ls_q    <= 1'b0;
      fs_q    <= 1'b0;
    end else begin
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
      de_q    <= de_d;
      x_q     <= x_d;
      y_q     <= y_d;
      ls_q    <= ls_d;
      fs_q    <= fs_d;
    end
  end

  assign vga.hsync_o       = hsync_q;
  assign vga.vsync_o       = vsync_q;
  assign vga.de_o          = de_q;
  assign vga.x_o           = x_q;
  assign vga.y_o           = y_q;
  assign vga.line_start_o  = ls_q;
  assign vga.frame_start_o = fs_q;

  // v terminal count is only needed by the counter itself
  logic unused_v_tc;
  assign unused_v_tc = v_tc;
endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench for vga_timing_gen on a reduced raster (25x15) so several
// frames, lock drops and resets fit in a short run.
module tb_vga_timing_gen;
  import vga_pkg::*;

  localparam int HA = 16, HFP = 2, HS = 4, HBP = 3;
  localparam int VA = 8,  VFP = 2, VS = 2, VBP = 3;
  localparam int HT = HA + HFP + HS + HBP;
  localparam int VT = VA + VFP + VS + VBP;
  localparam int FRAME = HT * VT;
  localparam logic SA = 1'b0;

  typedef struct packed {
    logic   clr;
    logic   hs, vs, de, ls, fs;
    coord_t x, y;
  } exp_t;

  logic clk = 1'b0;
  logic rst_i, lock_i;
  int   total = 0, bad = 0;
  int   p = 0;
  exp_t q[$];
  bit   stim_done = 1'b0;

  vga_timing_gen_if vif ();

  vga_timing_gen #(
    .H_ACTIVE (HA), .H_FP (HFP), .H_SYNC (HS), .H_BP (HBP),
    .V_ACTIVE (VA), .V_FP (VFP), .V_SYNC (VS), .V_BP (VBP),
    .SYNC_ACTIVE (SA)
  ) dut (
    .clk_i  (clk),
    .rst_i  (rst_i),
    .lock_i (lock_i),
    .vga    (vif)
  );

  always #5 clk = ~clk;

  // Reference: raster position is a single index into the frame; coordinates
  // and timing windows follow from plain arithmetic on that index.
  function automatic exp_t model(input logic r, input logic l);
    exp_t e;
    int x, y;
    e = '0;
    if (r || !l) begin
      e.clr = 1'b1;
      e.hs = ~SA; e.vs = ~SA;
      p = 0;
    end else begin
      x = p % HT;
      y = p / HT;
      e.x  = coord_t'(x);
      e.y  = coord_t'(y);
      e.de = (x < HA) && (y < VA);
      e.hs = (x >= HA + HFP && x < HA + HFP + HS) ? SA : ~SA;
      e.vs = (y >= VA + VFP && y < VA + VFP + VS) ? SA : ~SA;
      e.ls = (x == 0);
      e.fs = (p == 0);
      p = (p + 1) % FRAME;
    end
    return e;
  endfunction

  task automatic step(input logic r, input logic l);
    rst_i  = r;
    lock_i = l;
    @(posedge clk);
    #1;
    q.push_back(model(r, l));
  endtask

  // stimulus
  initial begin
    rst_i = 1'b1; lock_i = 1'b1;
    repeat (5) step(1'b1, 1'b1);
    // two and a bit clean frames
    repeat (2 * FRAME + 40) step(1'b0, 1'b1);
    // lock drop at pixel (10,5) for three cycles
    while (p != 5 * HT + 10) step(1'b0, 1'b1);
    repeat (3) step(1'b0, 1'b0);
    repeat (FRAME + 7) step(1'b0, 1'b1);
    // reset and lock loss together, reset released first
    repeat (3) step(1'b1, 1'b0);
    repeat (4) step(1'b0, 1'b0);
    repeat (FRAME / 2) step(1'b0, 1'b1);
    // random disturbances
    for (int i = 0; i < 3000; i++)
      step(($urandom_range(0, 249) == 0), ($urandom_range(0, 149) != 0));
    // settle into full clean frames for the per-frame statistics
    repeat (3 * FRAME + 5) step(1'b0, 1'b1);
    rst_i = 1'b0; lock_i = 1'b1;
    repeat (3) @(posedge clk);
    stim_done = 1'b1;
  end

  // monitor: per-cycle scoreboard compare plus whole-frame statistics
  int  cyc, hs_cnt, vs_cnt, de_cnt;
  bit  clean = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (q.size() != 0) begin
      e = q.pop_front();
      total++;
      if (vif.hsync_o !== e.hs || vif.vsync_o !== e.vs || vif.de_o !== e.de ||
          vif.x_o !== e.x || vif.y_o !== e.y ||
          vif.line_start_o !== e.ls || vif.frame_start_o !== e.fs) begin
        bad++;
        $display("FAIL pixel t=%0t got hs=%b vs=%b de=%b x=%0d y=%0d ls=%b fs=%b want hs=%b vs=%b de=%b x=%0d y=%0d ls=%b fs=%b",
                 $time, vif.hsync_o, vif.vsync_o, vif.de_o, vif.x_o, vif.y_o,
                 vif.line_start_o, vif.frame_start_o,
                 e.hs, e.vs, e.de, e.x, e.y, e.ls, e.fs);
      end
      if (e.clr) begin
        clean = 1'b0;
      end else if (vif.frame_start_o === 1'b1) begin
        if (clean) begin
          total++;
          if (cyc != FRAME || hs_cnt != HS * VT || vs_cnt != VS * HT || de_cnt != HA * VA) begin
            bad++;
            $display("FAIL frame_stats got period=%0d hs=%0d vs=%0d de=%0d want %0d %0d %0d %0d",
                     cyc, hs_cnt, vs_cnt, de_cnt, FRAME, HS * VT, VS * HT, HA * VA);
          end
        end
        clean = 1'b1;
        cyc = 0; hs_cnt = 0; vs_cnt = 0; de_cnt = 0;
      end
      if (clean) begin
        cyc++;
        if (vif.hsync_o === SA) hs_cnt++;
        if (vif.vsync_o === SA) vs_cnt++;
        if (vif.de_o === 1'b1)  de_cnt++;
      end
    end
  end

  // end of run: queue must have drained
  initial begin
    wait (stim_done);
    @(negedge clk);
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain got %0d pending want 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // hard bound on run time
  initial begin
    #500000;
    $display("FAIL watchdog got timeout want stimulus completion");
    $fatal(1, "watchdog");
  end
endmodule
